write_converter: RTL and testbench

Write-side counterpart of the bit-plane read path. Accepts a 256-bit word and a 7-bit word address, and scatters the word into the two 1024-bit memory planes (LSB plane and MSB plane) at every 8th bit of row `8*addr`. Other rows touch the remaining bits of each row, so every write is a read-modify-write: read both plane rows, overwrite the stride-8 bit positions, write both rows back. Sits between the compute side's write port and the dual-plane row memory, sharing the row address convention of the read converter.

---
 rtl/bitplane_pkg.sv | 22 ++
 rtl/write_converter_if.sv | 29 ++
 rtl/bitplane_merge.sv | 13 +
 rtl/write_converter.sv | 84 ++++++++
 tb/tb_write_converter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bitplane_pkg.sv
// Shared constants and types for the bit-plane read/write converters.
package bitplane_pkg;
  localparam int ROW_BITS   = 1024;
  localparam int WORD_BITS  = 256;
  localparam int PLANE_BITS = 128;
  localparam int STRIDE     = 8;
  localparam int WADDR_W    = 7;
  localparam int RADDR_W    = 10;
  localparam int NUM_PLANES = 2;

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} wc_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0]   addr;
    logic [WORD_BITS-1:0] data;
  } wr_req_t;

  // Word address to row address: each word owns a group of STRIDE rows.
  function automatic logic [RADDR_W-1:0] row_addr(input logic [WADDR_W-1:0] waddr);
    return {waddr, 3'b000};
  endfunction
endpackage

// File: rtl/write_converter_if.sv
// Write request port plus dual-plane row memory port of the write converter.
interface write_converter_if;
  import bitplane_pkg::*;

  logic                  w_valid;
  logic                  w_ready;
  logic [WADDR_W-1:0]    w_addr_in;
  logic [WORD_BITS-1:0]  w_data_in;
  logic [RADDR_W-1:0]    mem_addr_out;
  logic                  mem_rd_en;
  logic [0:ROW_BITS-1]   mem_rd_data_lsb;
  logic [0:ROW_BITS-1]   mem_rd_data_msb;
  logic                  mem_wr_en;
  logic [0:ROW_BITS-1]   mem_wr_data_lsb;
  logic [0:ROW_BITS-1]   mem_wr_data_msb;
  logic                  done;

  modport slave (
    input  w_valid, w_addr_in, w_data_in, mem_rd_data_lsb, mem_rd_data_msb,
    output w_ready, mem_addr_out, mem_rd_en, mem_wr_en, mem_wr_data_lsb,
           mem_wr_data_msb, done
  );

  modport master (
    output w_valid, w_addr_in, w_data_in, mem_rd_data_lsb, mem_rd_data_msb,
    input  w_ready, mem_addr_out, mem_rd_en, mem_wr_en, mem_wr_data_lsb,
           mem_wr_data_msb, done
  );
endinterface

// File: rtl/bitplane_merge.sv
// Scatters one plane slice onto every STRIDE-th bit of a row, keeping the rest.
module bitplane_merge
  import bitplane_pkg::*;
(
  input  logic [PLANE_BITS-1:0] slice_i,
  input  logic [0:ROW_BITS-1]   old_row_i,
  output logic [0:ROW_BITS-1]   new_row_o
);
  always_comb begin
    new_row_o = old_row_i;
    for (int i = 0; i < PLANE_BITS; i++) new_row_o[STRIDE*i] = slice_i[i];
  end
endmodule

// File: rtl/write_converter.sv
// Read-modify-write of one 256-bit word into the strided bits of both plane rows.
module write_converter
  import bitplane_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  write_converter_if.slave bus
);
  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  wc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_req_t          req_q;
  logic             w_ready_q, rd_en_q, wr_en_q, done_q;
  logic             accept, rd_fire;

  logic [NUM_PLANES-1:0][0:ROW_BITS-1] old_rows, new_rows, wr_rows_q;

  assign accept  = bus.w_valid && w_ready_q;
  assign rd_fire = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RD;
      RD: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = WR;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      w_ready_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_rows_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_ready_q <= (state_d == IDLE);
      rd_en_q   <= (state_d == RD);
      wr_en_q   <= (state_d == WR);
      done_q    <= (state_d == WR);
      if (accept)  req_q     <= '{addr: bus.w_addr_in, data: bus.w_data_in};
      if (rd_fire) wr_rows_q <= new_rows;
    end
  end

  assign old_rows[0] = bus.mem_rd_data_lsb;
  assign old_rows[1] = bus.mem_rd_data_msb;

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    bitplane_merge u_merge (
      .slice_i   (req_q.data[p*PLANE_BITS +: PLANE_BITS]),
      .old_row_i (old_rows[p]),
      .new_row_o (new_rows[p])
    );
  end

  assign bus.w_ready         = w_ready_q;
  assign bus.mem_addr_out    = row_addr(req_q.addr);
  assign bus.mem_rd_en       = rd_en_q;
  assign bus.mem_wr_en       = wr_en_q;
  assign bus.done            = done_q;
  assign bus.mem_wr_data_lsb = wr_rows_q[0];
  assign bus.mem_wr_data_msb = wr_rows_q[1];
endmodule

// File: tb/tb_write_converter.sv
// Scoreboard bench: two converters (read latency 1 and 3) with a read-bus model driving decoys.
module tb_write_converter;
  import bitplane_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             vld;
  logic [1:0][6:0]        addr;
  logic [1:0][255:0]      data;
  logic [1:0][0:1023]     old_l, old_m;
  logic [1:0]             rdy, rd_en, wr_en, dn;
  logic [1:0][9:0]        maddr;
  logic [1:0][0:1023]     wl, wm;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;
    int age;
    write_converter_if bus();
    write_converter #(.RD_LATENCY(LAT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.w_valid   = vld[k];
    assign bus.w_addr_in = addr[k];
    assign bus.w_data_in = data[k];
    // Real row only in the cycle RD_LATENCY after the read strobe; inverted row otherwise.
    assign bus.mem_rd_data_lsb = (age == LAT) ? old_l[k] : ~old_l[k];
    assign bus.mem_rd_data_msb = (age == LAT) ? old_m[k] : ~old_m[k];
    assign rdy[k]   = bus.w_ready;
    assign rd_en[k] = bus.mem_rd_en;
    assign wr_en[k] = bus.mem_wr_en;
    assign dn[k]    = bus.done;
    assign maddr[k] = bus.mem_addr_out;
    assign wl[k]    = bus.mem_wr_data_lsb;
    assign wm[k]    = bus.mem_wr_data_msb;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   age <= 0;
      else if (bus.mem_rd_en)       age <= 1;
      else if (age > 0 && age < 64) age <= age + 1;
    end
  end

  typedef struct {
    logic [9:0]    addr;
    logic [0:1023] l;
    logic [0:1023] m;
    int            acc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, last_acc = 0, prev_acc = 0, spurious = 0;

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [0:1023] model(logic [127:0] s, logic [0:1023] old);
    logic [0:1023] r = old;
    for (int i = 0; i < 128; i++) r[8*i] = s[i];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [0:1023] rnd1024();
    logic [0:1023] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Row compare goes through chk on the first differing 64-bit chunk.
  task automatic chk_row(string tag, logic [0:1023] got, logic [0:1023] exp);
    int j = 0;
    for (int i = 15; i >= 0; i--) if (got[64*i +: 64] !== exp[64*i +: 64]) j = i;
    chk($sformatf("%s[%0d]", tag, j), got[64*j +: 64], exp[64*j +: 64]);
  endtask

  task automatic tick(int k);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rd_en[k]) chk("rd_lat", 64'(cyc - last_acc), 64'd1);
    if (dn[k] && !wr_en[k]) spurious++;
    if (wr_en[k]) begin
      if (q.size() == 0) spurious++;
      else begin
        e = q.pop_front();
        chk("wr_lat", 64'(cyc - e.acc), 64'(2 + lat(k)));
        chk("wr_addr", 64'(maddr[k]), 64'(e.addr));
        chk("done", 64'(dn[k]), 64'd1);
        chk_row("wr_lsb", wl[k], e.l);
        chk_row("wr_msb", wm[k], e.m);
      end
    end
    if (rdy[k] && vld[k]) begin
      prev_acc = last_acc;
      last_acc = cyc;
      acc_cnt++;
      e.addr = 10'(addr[k]) * 10'd8;
      e.l    = model(data[k][127:0], old_l[k]);
      e.m    = model(data[k][255:128], old_m[k]);
      e.acc  = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [6:0] a, logic [255:0] d);
    int n0 = acc_cnt;
    int t = 0;
    vld[k] = 1'b1; addr[k] = a; data[k] = d;
    while (acc_cnt == n0 && t < 20) begin tick(k); t++; end
    chk("accept", 64'(acc_cnt - n0), 64'd1);
    vld[k] = 1'b0; addr[k] = ~a; data[k] = ~d;
  endtask

  task automatic drain(int k);
    int t = 0;
    while (q.size() > 0 && t < 30) begin tick(k); t++; end
    chk("drain", 64'(q.size()), 64'd0);
    tick(k);
  endtask

  initial begin
    logic [255:0] d1, d2;
    vld = '0; addr = '0; data = '0; old_l = '0; old_m = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdy", 64'(rdy[k]), 64'd0);
      chk("rst_rd_en", 64'(rd_en[k]), 64'd0);
      chk("rst_wr_en", 64'(wr_en[k]), 64'd0);
      chk("rst_done", 64'(dn[k]), 64'd0);
      chk("rst_addr", 64'(maddr[k]), 64'd0);
      chk_row("rst_wl", wl[k], '0);
      chk_row("rst_wm", wm[k], '0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rdy_before_edge", 64'(rdy[0]), 64'd0);
    @(negedge clk); chk("rdy_after_edge0", 64'(rdy[0]), 64'd1);
    chk("rdy_after_edge1", 64'(rdy[1]), 64'd1);
    @(posedge clk); #1;

    // all-ones word into zero rows at addr 5
    send(0, 7'd5, '1);
    chk("addr40", 64'(maddr[0]), 64'd40);
    drain(0);
    chk_row("ones_lsb", wl[0], {128{8'h80}});
    chk_row("ones_msb", wm[0], {128{8'h80}});

    // zero word into all-ones rows preserves the other bits
    old_l[0] = '1; old_m[0] = '1;
    send(0, 7'd7, '0);
    drain(0);
    chk_row("keep_lsb", wl[0], {128{8'h7F}});
    chk_row("keep_msb", wm[0], {128{8'h7F}});

    // plane split
    old_l[0] = '0; old_m[0] = '0;
    send(0, 7'd9, {128'h0, 128'h1});
    drain(0);
    chk_row("split_lsb", wl[0], {8'h80, 1016'h0});
    chk_row("split_msb", wm[0], '0);

    // back-to-back with valid held high
    old_l[0] = rnd1024(); old_m[0] = rnd1024();
    d1 = rnd256(); d2 = rnd256();
    send(0, 7'd0, d1);
    send(0, 7'd127, d2);
    chk("b2b_gap", 64'(last_acc - prev_acc), 64'(lat(0) + 3));
    chk("addr1016", 64'(maddr[0]), 64'd1016);
    drain(0);

    // latency 3 with decoys on the read bus
    for (int n = 0; n < 3; n++) begin
      old_l[1] = rnd1024(); old_m[1] = rnd1024();
      send(1, 7'($urandom_range(0, 127)), rnd256());
      drain(1);
    end

    // reset while waiting for read data
    send(1, 7'd12, rnd256());
    tick(1); tick(1);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_rdy", 64'(rdy[1]), 64'd0);
    chk("midrst_wr_en", 64'(wr_en[1]), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("midrst_rdy_pre", 64'(rdy[1]), 64'd0);
    @(negedge clk); chk("midrst_rdy_post", 64'(rdy[1]), 64'd1);
    @(posedge clk); #1;
    spurious = 0;
    repeat (10) tick(1);
    chk("no_wr_after_rst", 64'(spurious), 64'd0);

    // recovery write after the dropped one
    old_l[1] = rnd1024(); old_m[1] = rnd1024();
    send(1, 7'd64, rnd256());
    drain(1);
    chk("no_spurious", 64'(spurious), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
